demux1to8_reg: RTL

//  Registered 1-to-8 demultiplexer/distributor: steers one WIDTH-bit word from
//  a single valid/ready source to one of eight destination channels chosen by sel.

---
 rtl/demux1to8_reg.sv | 105 ++++++++++
 1 files changed

// File: rtl/demux1to8_reg.sv
// Registered 1-to-8 distributor: one valid/ready source steered by in_sel into
// eight one-entry holding slots, each with its own valid/ready handshake.
module demux1to8_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [8];
  slot_state_e      state_d [8];
  logic [7:0]       load;
  logic [WIDTH-1:0] data_q  [8];
  logic [CNT_W-1:0] count_q;
  logic             accept;

  // Readiness looks only at the addressed slot, so a stalled consumer never
  // blocks traffic headed elsewhere; a FULL slot being popped can reload.
  assign in_ready = rst_n && enable && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid = 8'h00;
    for (int i = 0; i < 8; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  always_comb begin
    load = 8'h00;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY: begin
          if (accept && (in_sel == i[2:0])) begin
            state_d[i] = FULL;
            load[i]    = 1'b1;
          end
        end
        FULL: begin
          if (accept && (in_sel == i[2:0])) begin
            load[i] = 1'b1;
          end else if (out_ready[i]) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  // Reset discards held words even mid-stall; data only moves on a load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= state_d[i];
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
      if (accept) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign out0       = data_q[0];
  assign out1       = data_q[1];
  assign out2       = data_q[2];
  assign out3       = data_q[3];
  assign out4       = data_q[4];
  assign out5       = data_q[5];
  assign out6       = data_q[6];
  assign out7       = data_q[7];
  assign xfer_count = count_q;

endmodule
